// File: rtl/posit_encoder_pkg.sv
// posit_encoder_pkg: posit sign/word types, unpacked posit struct and format constants
package posit_encoder_pkg;
    typedef enum logic {POS = 1'b0, NEG = 1'b1} sign_t;
    typedef logic [31:0] posit32_t;
    typedef logic [63:0] posit64_t;
    localparam int POSIT_ES = 2;
    localparam posit32_t POSIT32_MAXPOS = 32'h7FFF_FFFF;
    localparam posit32_t POSIT32_MINPOS = 32'h0000_0001;
    localparam posit32_t POSIT32_NAR = 32'h8000_0000;
    localparam posit64_t POSIT64_MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam posit64_t POSIT64_MINPOS = 64'h0000_0000_0000_0001;
    localparam posit64_t POSIT64_NAR = 64'h8000_0000_0000_0000;
    typedef struct packed {
        sign_t s;
        logic zero;
        logic nar;
        logic signed [7:0] scale;
        logic [27:0] frac;
    } posit_unpacked_t;
endpackage

// File: rtl/posit_encoder_if.sv
// posit_encoder_if: unpacked-posit input stream and encoded-posit output stream
interface posit_encoder_if import posit_encoder_pkg::*; #(
    parameter int N = 32,
    parameter int FRAC_W = 28,
    parameter int SCALE_W = 8
);
    logic in_valid;
    logic in_ready;
    sign_t in_sign;
    logic signed [SCALE_W-1:0] in_scale;
    logic [FRAC_W-1:0] in_frac;
    logic in_zero;
    logic in_nar;
    logic out_valid;
    logic out_ready;
    logic [N-1:0] out_posit;
    modport master (
        output in_valid, in_sign, in_scale, in_frac, in_zero, in_nar, out_ready,
        input in_ready, out_valid, out_posit
    );
    modport slave (
        input in_valid, in_sign, in_scale, in_frac, in_zero, in_nar, out_ready,
        output in_ready, out_valid, out_posit
    );
endinterface

// File: rtl/posit_encoder_round_rne.sv
// posit_round_rne: round-to-nearest-even on the posit magnitude, never yielding 0 or NaR
module posit_round_rne #(
    parameter int W = 31
) (
    input  logic [W-1:0] m_i,
    input  logic         g_i,
    input  logic         st_i,
    input  logic         sat_hi_i,
    input  logic         sat_lo_i,
    output logic [W-1:0] m_o
);
    logic [W:0] sum;
    assign sum = {1'b0, m_i} + (W+1)'(g_i & (st_i | m_i[0]));
    assign m_o = (sat_hi_i || sum[W]) ? '1
               : (sat_lo_i || sum[W-1:0] == '0) ? W'(1)
               : sum[W-1:0];
endmodule

// File: rtl/posit_encoder.sv
// posit_encoder: two-stage pipeline packing sign/scale/fraction into a posit word with RNE rounding
module posit_encoder import posit_encoder_pkg::*; #(
    parameter int N = 32,
    parameter int ES = 2,
    parameter int FRAC_W = 28,
    parameter int SCALE_W = 8
) (
    input logic clk,
    input logic rst,
    posit_encoder_if.slave bus
);
    localparam int L = N - 1 + ES + FRAC_W + 2;
    localparam int PAD = L - ES - FRAC_W;
    localparam logic signed [SCALE_W-1:0] SAT = SCALE_W'((N - 2) << ES);
    logic s2_adv, s1_adv;
    logic signed [SCALE_W-1:0] k;
    logic [SCALE_W-1:0] rlen;
    logic [L-1:0] regime, str_d, str_q;
    logic s1_valid_q, sign_q, zero_q, nar_q, sat_hi_q, sat_lo_q;
    logic out_valid_q;
    logic [N-1:0] posit_d, posit_q;
    logic [N-2:0] m_rnd;
    assign s2_adv = !out_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_posit = posit_q;
    // regime length: k+2 bits for k>=0 (ones run + terminator), 1-k bits for k<0
    assign k = bus.in_scale >>> ES;
    assign rlen = k[SCALE_W-1] ? SCALE_W'(1) - $unsigned(k) : $unsigned(k) + SCALE_W'(2);
    assign regime = k[SCALE_W-1] ? ({1'b1, {(L-1){1'b0}}} >> (rlen - SCALE_W'(1)))
                                 : ~({L{1'b1}} >> (rlen - SCALE_W'(1)));
    assign str_d = regime | ({bus.in_scale[ES-1:0], bus.in_frac, {PAD{1'b0}}} >> rlen);
    posit_round_rne #(.W(N - 1)) u_round (
        .m_i(str_q[L-1 -: N-1]),
        .g_i(str_q[L-N]),
        .st_i(|str_q[L-N-1:0]),
        .sat_hi_i(sat_hi_q),
        .sat_lo_i(sat_lo_q),
        .m_o(m_rnd)
    );
    assign posit_d = nar_q ? {1'b1, {(N-1){1'b0}}}
                   : zero_q ? '0
                   : sign_q ? -{1'b0, m_rnd} : {1'b0, m_rnd};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            str_q <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            nar_q <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            out_valid_q <= 1'b0;
            posit_q <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= bus.in_valid;
            if (s1_adv && bus.in_valid) begin
                str_q <= str_d;
                sign_q <= bus.in_sign == NEG;
                zero_q <= bus.in_zero;
                nar_q <= bus.in_nar;
                sat_hi_q <= bus.in_scale >= SAT;
                sat_lo_q <= bus.in_scale < -SAT;
            end
            if (s2_adv) out_valid_q <= s1_valid_q;
            if (s2_adv && s1_valid_q) posit_q <= posit_d;
        end
    end
endmodule

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder: directed and random scoreboard checks of the posit encoder pipeline
module tb_posit_encoder;
    import posit_encoder_pkg::*;
    typedef struct {logic [31:0] v; int c;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0, checks = 0, cyc = 0;
    logic rand_rdy = 1'b0, took = 1'b0;
    logic [31:0] pend = '0;
    exp_t q[$];
    posit_encoder_if #(.N(32), .FRAC_W(28), .SCALE_W(8)) bus ();
    posit_encoder #(.N(32), .ES(2), .FRAC_W(28), .SCALE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // independent bitwise model: lay regime, exponent and fraction into a wide string
    function automatic logic [31:0] ref_enc(logic s, logic z, logic n, logic signed [7:0] sc, logic [27:0] f);
        logic [127:0] b;
        int p, v, e, k;
        logic [31:0] mag;
        if (n) return 32'h8000_0000;
        if (z) return 32'h0;
        b = '0;
        p = 127;
        v = sc;
        e = v & 3;
        k = (v - e) / 4;
        if (v >= 120) mag = 32'h7FFF_FFFF;
        else if (v < -120) mag = 32'h1;
        else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin b[p] = 1'b1; p--; end
                b[p] = 1'b0; p--;
            end else begin
                p += k;
                b[p] = 1'b1; p--;
            end
            b[p] = e[1]; p--;
            b[p] = e[0]; p--;
            for (int i = 27; i >= 0; i--) begin b[p] = f[i]; p--; end
            mag = {1'b0, b[127:97]};
            if (b[96] && ((|b[95:0]) || b[97])) mag++;
            if (mag > 32'h7FFF_FFFF) mag = 32'h7FFF_FFFF;
            if (mag == 0) mag = 32'h1;
        end
        return s ? -mag : mag;
    endfunction
    task automatic cycle();
        exp_t e;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        cyc++;
        took = 1'b0;
        if (!bus.in_ready)
            chk("in_ready_drop", {bus.out_valid, bus.out_ready, 30'(q.size())}, {1'b1, 1'b0, 30'd2});
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("spurious", 32'(bus.out_valid), 32'h0);
            else begin
                e = q.pop_front();
                chk("data", bus.out_posit, e.v);
                if (!rand_rdy) chk("latency", 32'(cyc - e.c), 32'd2);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            q.push_back('{pend, cyc});
            took = 1'b1;
        end
        @(negedge clk);
    endtask
    task automatic send(logic s, logic z, logic n, logic signed [7:0] sc, logic [27:0] f, logic [31:0] exp);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_sign = sign_t'(s);
        bus.in_zero = z;
        bus.in_nar = n;
        bus.in_scale = sc;
        bus.in_frac = f;
        pend = exp;
        do begin cycle(); w++; end while (!took && w < 40);
        if (!took) chk("accept_timeout", 32'(took), 32'h1);
        bus.in_valid = 1'b0;
    endtask
    task automatic drain();
        int w;
        w = 0;
        bus.out_ready = 1'b1;
        while (q.size() > 0 && w < 40) begin cycle(); w++; end
        chk("drain", 32'(q.size()), 32'h0);
    endtask
    initial begin
        logic s, z, n;
        logic signed [7:0] sc;
        logic [27:0] f;
        bus.in_valid = 1'b0;
        bus.in_sign = POS;
        bus.in_scale = '0;
        bus.in_frac = '0;
        bus.in_zero = 1'b0;
        bus.in_nar = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_posit", bus.out_posit, 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        send(0, 0, 0, 8'sd0, 28'h0, 32'h4000_0000);
        send(1, 0, 0, 8'sd0, 28'h0, 32'hC000_0000);
        send(0, 0, 0, 8'sd1, 28'h0, 32'h4800_0000);
        send(0, 0, 0, 8'sd0, 28'h800_0000, 32'h4400_0000);
        send(0, 0, 0, 8'sd0, 28'h000_0001, 32'h4000_0000);
        send(0, 0, 0, 8'sd0, 28'h000_0003, 32'h4000_0002);
        send(0, 0, 0, 8'sd120, 28'h0, 32'h7FFF_FFFF);
        send(0, 0, 0, 8'sd127, 28'h0, 32'h7FFF_FFFF);
        send(0, 0, 0, -8'sd128, 28'hFFF_FFFF, 32'h0000_0001);
        send(1, 0, 0, -8'sd120, 28'h0, 32'hFFFF_FFFF);
        send(1, 1, 0, 8'sd5, 28'h123_4567, 32'h0000_0000);
        send(0, 1, 1, 8'sd5, 28'h123_4567, POSIT32_NAR);
        drain();
        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            z = ($urandom_range(0, 15) == 0);
            n = ($urandom_range(0, 15) == 0);
            sc = 8'($urandom_range(0, 255));
            f = 28'($urandom);
            send(s, z, n, sc, f, ref_enc(s, z, n, sc, f));
        end
        rand_rdy = 1'b0;
        drain();
        bus.out_ready = 1'b0;
        send(0, 0, 0, 8'sd4, 28'h0, 32'h6000_0000);
        send(0, 0, 0, 8'sd8, 28'h0, 32'h7000_0000);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_out_posit", bus.out_posit, 32'h0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        send(1, 0, 0, -8'sd4, 28'h0, 32'hE000_0000);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
